// File: rtl/mul16_seq.sv
// Sequential 16-bit unsigned shift-and-add multiplier with START/BUSY/DONE handshake.
// One adder forms every partial sum; returns the low word of A*B plus an overflow flag.
module mul16_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] PRODUCT,
  output logic             OVF
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_i_q, ovf_i_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             ovf_q, ovf_d;

  // Single shared adder; the extra top bit is the carry out of the partial sum.
  logic [WIDTH:0]   sum;
  assign sum = {1'b0, acc_q} + {1'b0, mcand_q};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_i_d   = ovf_i_q;
    product_d = product_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          mcand_d  = A;
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
          ovf_i_d  = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (mplier_q[0]) begin
          acc_d = sum[WIDTH-1:0];
          if (sum[WIDTH]) ovf_i_d = 1'b1;
        end
        // A set top bit about to be shifted out is still needed if any multiplier bits remain.
        if (mcand_q[WIDTH-1] && ((mplier_q >> 1) != '0)) ovf_i_d = 1'b1;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (count_q == 4'd15) begin
          state_d   = StDone;
          product_d = acc_d;
          ovf_d     = ovf_i_d;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      ovf_i_q   <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      ovf_i_q   <= ovf_i_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign BUSY    = (state_q == StRun);
  assign DONE    = (state_q == StDone);
  assign PRODUCT = product_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed self-checking bench for mul16_seq: latency, products, overflow, reset abort, hold.
module tb_mul16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  mul16_seq #(.WIDTH(16)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .START  (start),
    .A      (a),
    .B      (b),
    .BUSY   (busy),
    .DONE   (done),
    .PRODUCT(product),
    .OVF    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; sampling and driving happen 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply and count cycles after the accepting edge until DONE is seen.
  task automatic run_mul(input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] prod, output logic of,
                         output int lat, output logic seen);
    a     = ia;
    b     = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 16'hdead;
    b     = 16'hbeef;
    lat   = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    seen = done;
    prod = product;
    of   = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a     = 16'd7;
    b     = 16'd9;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%0d ovf=%b, required 0 0 0 0",
               busy, done, product, ovf);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    a     = 16'd100;
    b     = 16'd200;
    start = 1'b1;
    tick();  // E0
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy E%0d: busy=%b done=%b, required 1 0", k - 1, busy, done);
      end
      tick();
    end
    tick();  // E16
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== 16'd20000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_done E16: done=%b busy=%b product=%0d ovf=%b, required 1 0 20000 0",
               done, busy, product, ovf);
    end
    tick();  // E17
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'd20000) begin
      errors++;
      $display("FAIL basic_after E17: done=%b busy=%b product=%0d, required 0 0 20000",
               done, busy, product);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va[5]   = '{16'd500, 16'd255, 16'd256, 16'd65535, 16'd0};
    logic [15:0] vb[5]   = '{16'd1000, 16'd257, 16'd256, 16'd65535, 16'd65535};
    logic [15:0] vp[5]   = '{16'd41248, 16'd65535, 16'd0, 16'd1, 16'd0};
    logic        vo[5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] p;
    logic        o;
    logic        seen;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_mul(va[i], vb[i], p, o, lat, seen);
      checks++;
      if (!seen || lat != 16) begin
        errors++;
        $display("FAIL vec%0d_latency: done_seen=%b cycles=%0d, required 1 16", i, seen, lat);
      end
      checks++;
      if (p !== vp[i] || o !== vo[i]) begin
        errors++;
        $display("FAIL vec%0d_result %0d*%0d: product=%0d ovf=%b, required %0d %b",
                 i, va[i], vb[i], p, o, vp[i], vo[i]);
      end
      tick();
    end
  endtask

  task automatic test_start_held();
    int wait_cyc;
    int lat;
    a     = 16'd3;
    b     = 16'd5;
    start = 1'b1;
    tick();  // E0, START stays high from here on
    a = 16'd7;
    b = 16'd9;
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL held_busy E%0d: busy=%b done=%b, required 1 0", k, busy, done);
      end
      tick();
    end
    tick();  // E16
    checks++;
    if (done !== 1'b1 || product !== 16'd15 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL held_first: done=%b product=%0d ovf=%b, required 1 15 0",
               done, product, ovf);
    end
    wait_cyc = 0;
    while (!busy && wait_cyc < 4) begin
      tick();
      wait_cyc++;
    end
    checks++;
    if (busy !== 1'b1 || wait_cyc > 2) begin
      errors++;
      $display("FAIL held_restart: busy=%b after %0d cycles, required 1 within 2", busy, wait_cyc);
    end
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL held_second_busy cycle %0d: busy=%b, required 1", lat, busy);
      end
      tick();
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat != 16 || product !== 16'd63 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL held_second: done=%b cycles=%0d product=%0d ovf=%b, required 1 16 63 0",
               done, lat, product, ovf);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p;
    logic        o;
    logic        seen;
    int          lat;
    int          pulses;
    a     = 16'd100;
    b     = 16'd200;
    start = 1'b1;
    tick();  // E0
    start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    rst_n = 1'b0;
    tick();  // E8
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b product=%0d ovf=%b, required 0 0 0 0",
               busy, done, product, ovf);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrun_no_done: active cycles=%0d, required 0", pulses);
    end
    run_mul(16'd12, 16'd34, p, o, lat, seen);
    checks++;
    if (!seen || lat != 16 || p !== 16'd408 || o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_fresh: seen=%b cycles=%0d product=%0d ovf=%b, required 1 16 408 0",
               seen, lat, p, o);
    end
    tick();
  endtask

  task automatic test_hold();
    logic [15:0] p;
    logic        o;
    logic        seen;
    int          lat;
    int          bad;
    run_mul(16'd100, 16'd200, p, o, lat, seen);
    checks++;
    if (!seen || p !== 16'd20000 || o !== 1'b0) begin
      errors++;
      $display("FAIL hold_setup: seen=%b product=%0d ovf=%b, required 1 20000 0", seen, p, o);
    end
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (product !== 16'd20000 || done !== 1'b0 || ovf !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_50: cycles with changed output=%0d (product=%0d done=%b), required 0",
               bad, product, done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_start_held();
    test_reset_mid_run();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
